// File: rtl/wash_program_sequencer.sv
// wash_program_sequencer: timed washing-machine program controller.
//   Sequence: lock, fill, heat, wash, drain, RINSE_N rinse rounds (fill, rinse, drain), spin,
//   unlock. Fill/heat timeouts go to an error state, and abort drains and returns to idle.
//   Optional feature macro: WPS_PAUSE_EN (adds pause_i, which freezes the running phase).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pause_i               freeze request (only with WPS_PAUSE_EN)
//   start_i, abort_i      front-panel levels
//   full_i, hot_i         water-level and temperature sensors
//   valve_o .. door_lock_o  registered actuator drives
//   busy_o, done_o        status; done_o pulses for one cycle in UNLOCK
//   err_code_o            01 fill timeout, 10 heat timeout; non-zero only in ERROR
//   phase_o               current state code
module wash_program_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TICK_DIV = 50,
    parameter int unsigned FILL_TO  = 200,
    parameter int unsigned HEAT_TO  = 400,
    parameter int unsigned WASH_T   = 300,
    parameter int unsigned RINSE_T  = 120,
    parameter int unsigned DRAIN_T  = 100,
    parameter int unsigned RINSE_N  = 2,
    parameter int unsigned SPIN_T   = 150
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef WPS_PAUSE_EN
    input  logic       pause_i,
`endif
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       full_i,
    input  logic       hot_i,
    output logic       valve_o,
    output logic       heater_o,
    output logic       motor_o,
    output logic       pump_o,
    output logic       door_lock_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] err_code_o,
    output logic [3:0] phase_o
);

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StLock       = 4'd1,
        StFill       = 4'd2,
        StHeat       = 4'd3,
        StWash       = 4'd4,
        StDrain      = 4'd5,
        StRfill      = 4'd6,
        StRinse      = 4'd7,
        StRdrain     = 4'd8,
        StSpin       = 4'd9,
        StUnlock     = 4'd10,
        StAbortDrain = 4'd11,
        StError      = 4'd15
    } state_e;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // One spare count so rinse_q + 1 never wraps, even with RINSE_N = 0.
    localparam int unsigned RW = $clog2(RINSE_N + 2);

    localparam logic [PW-1:0]    PrescLast = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LockLast  = '0;
    localparam logic [CNT_W-1:0] FillLast  = CNT_W'(FILL_TO - 1);
    localparam logic [CNT_W-1:0] HeatLast  = CNT_W'(HEAT_TO - 1);
    localparam logic [CNT_W-1:0] WashLast  = CNT_W'(WASH_T - 1);
    localparam logic [CNT_W-1:0] RinseLast = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] DrainLast = CNT_W'(DRAIN_T - 1);
    localparam logic [CNT_W-1:0] SpinLast  = CNT_W'(SPIN_T - 1);
    localparam logic [RW-1:0]    RinseNum  = RW'(RINSE_N);

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [RW-1:0]    rinse_q, rinse_d, rinse_inc;
    logic [1:0]       err_d;
    logic             pause_w, abort_take, hold, tick, state_chg;

`ifdef WPS_PAUSE_EN
    assign pause_w = pause_i;
`else
    assign pause_w = 1'b0;
`endif

    assign rinse_inc = rinse_q + 1'b1;

    always_comb begin
        abort_take = abort_i &&
                     (((state_q >= StLock) && (state_q <= StSpin)) || (state_q == StError));
        // Pause freezes everything, including sensor decisions; abort overrides it.
        hold       = pause_w && !abort_take &&
                     (((state_q >= StFill) && (state_q <= StSpin)) || (state_q == StAbortDrain));
        tick       = (presc_q == PrescLast) && !hold;

        state_d = state_q;
        rinse_d = rinse_q;
        err_d   = err_code_o;

        if (abort_take) begin
            state_d = StAbortDrain;
        end else if (!hold) begin
            case (state_q)
                StIdle: begin
                    rinse_d = '0;
                    if (start_i) state_d = StLock;
                end
                StLock:  if (tick && tmr_q == LockLast) state_d = StFill;
                StFill, StRfill: begin
                    // Sensor is checked first so it wins over a coincident timeout.
                    if (full_i) begin
                        state_d = (state_q == StFill) ? StHeat : StRinse;
                    end else if (tick && tmr_q == FillLast) begin
                        state_d = StError;
                        err_d   = 2'b01;
                    end
                end
                StHeat: begin
                    if (hot_i) begin
                        state_d = StWash;
                    end else if (tick && tmr_q == HeatLast) begin
                        state_d = StError;
                        err_d   = 2'b10;
                    end
                end
                StWash:  if (tick && tmr_q == WashLast) state_d = StDrain;
                StDrain: begin
                    if (tick && tmr_q == DrainLast) state_d = (RINSE_N > 0) ? StRfill : StSpin;
                end
                StRinse: if (tick && tmr_q == RinseLast) state_d = StRdrain;
                StRdrain: begin
                    if (tick && tmr_q == DrainLast) begin
                        rinse_d = rinse_inc;
                        state_d = (rinse_inc < RinseNum) ? StRfill : StSpin;
                    end
                end
                StSpin:       if (tick && tmr_q == SpinLast) state_d = StUnlock;
                StUnlock:     state_d = StIdle;
                StAbortDrain: if (tick && tmr_q == DrainLast) state_d = StIdle;
                StError:      state_d = StError;
                default:      state_d = StIdle;
            endcase
        end

        if (state_d != StError) err_d = 2'b00;

        state_chg = (state_d != state_q);

        if (state_chg || tick) begin
            presc_d = '0;
        end else if (hold) begin
            presc_d = presc_q;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Tick counter saturates rather than wrapping.
        if (state_chg) begin
            tmr_d = '0;
        end else if (tick && (tmr_q != '1)) begin
            tmr_d = tmr_q + 1'b1;
        end else begin
            tmr_d = tmr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            tmr_q       <= '0;
            rinse_q     <= '0;
            valve_o     <= 1'b0;
            heater_o    <= 1'b0;
            motor_o     <= 1'b0;
            pump_o      <= 1'b0;
            door_lock_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_code_o  <= 2'b00;
            phase_o     <= 4'd0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tmr_q       <= tmr_d;
            rinse_q     <= rinse_d;
            // Outputs decode the next state so they move on the same edge as phase.
            valve_o     <= !hold && (state_d == StFill || state_d == StRfill);
            heater_o    <= !hold && (state_d == StHeat);
            motor_o     <= !hold && (state_d == StWash || state_d == StRinse ||
                                     state_d == StSpin);
            pump_o      <= !hold && (state_d == StDrain || state_d == StRdrain ||
                                     state_d == StSpin || state_d == StAbortDrain);
            door_lock_o <= (state_d != StIdle) && (state_d != StUnlock);
            busy_o      <= (state_d != StIdle);
            done_o      <= (state_d == StUnlock);
            err_code_o  <= err_d;
            phase_o     <= state_d;
        end
    end

endmodule
